// File: rtl/lcd_text_pkg.sv
// lcd_text_pkg: shared constants and types for the LCD text writer.
//   Screen geometry (84x48 pixels, six 8-pixel banks), text grid (14x6 cells of
//   6 pixels), FSM state encoding and the 5-column glyph type.
package lcd_text_pkg;

    localparam int unsigned LCD_COLS     = 84;
    localparam int unsigned LCD_BANKS    = 6;
    localparam int unsigned TEXT_COLS    = 14;
    localparam int unsigned TEXT_ROWS    = 6;
    localparam int unsigned GLYPH_W      = 5;
    localparam int unsigned CELL_W       = 6;
    localparam int unsigned CLEAR_WRITES = LCD_COLS * LCD_BANKS;

    // Glyph columns; index 0 is the leftmost column, bit0 the top pixel.
    typedef logic [GLYPH_W-1:0][7:0] glyph_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        EMIT,
        GAP,
        CLEAR_EMIT,
        CLEAR_GAP
    } state_t;

endpackage

// File: rtl/lcd_font_rom.sv
// lcd_font_rom: 96-entry 5x7 ASCII font (0x20..0x7F), synchronous read.
//   clk   in   clock
//   code  in   7-bit ASCII code
//   glyph out  5 column bytes, registered; all zero for codes < 0x20 and 0x7F
module lcd_font_rom
    import lcd_text_pkg::*;
(
    input  logic       clk,
    input  logic [6:0] code,
    output glyph_t     glyph
);

    // Glyph packed leftmost column in the most significant byte.
    function automatic logic [39:0] font(input logic [6:0] c);
        logic [39:0] f;
        case (c)
            7'h21: f = 40'h00005F0000;  7'h22: f = 40'h0007000700;
            7'h23: f = 40'h147F147F14;  7'h24: f = 40'h242A7F2A12;
            7'h25: f = 40'h2313086462;  7'h26: f = 40'h3649552250;
            7'h27: f = 40'h0005030000;  7'h28: f = 40'h001C224100;
            7'h29: f = 40'h0041221C00;  7'h2A: f = 40'h14083E0814;
            7'h2B: f = 40'h08083E0808;  7'h2C: f = 40'h0050300000;
            7'h2D: f = 40'h0808080808;  7'h2E: f = 40'h0060600000;
            7'h2F: f = 40'h2010080402;  7'h30: f = 40'h3E5149453E;
            7'h31: f = 40'h00427F4000;  7'h32: f = 40'h4261514946;
            7'h33: f = 40'h2141454B31;  7'h34: f = 40'h1814127F10;
            7'h35: f = 40'h2745454539;  7'h36: f = 40'h3C4A494930;
            7'h37: f = 40'h0171090503;  7'h38: f = 40'h3649494936;
            7'h39: f = 40'h064949291E;  7'h3A: f = 40'h0036360000;
            7'h3B: f = 40'h0056360000;  7'h3C: f = 40'h0814224100;
            7'h3D: f = 40'h1414141414;  7'h3E: f = 40'h0041221408;
            7'h3F: f = 40'h0201510906;  7'h40: f = 40'h324979413E;
            7'h41: f = 40'h7E1111117E;  7'h42: f = 40'h7F49494936;
            7'h43: f = 40'h3E41414122;  7'h44: f = 40'h7F4141221C;
            7'h45: f = 40'h7F49494941;  7'h46: f = 40'h7F09090901;
            7'h47: f = 40'h3E4149497A;  7'h48: f = 40'h7F0808087F;
            7'h49: f = 40'h00417F4100;  7'h4A: f = 40'h2040413F01;
            7'h4B: f = 40'h7F08142241;  7'h4C: f = 40'h7F40404040;
            7'h4D: f = 40'h7F020C027F;  7'h4E: f = 40'h7F0408107F;
            7'h4F: f = 40'h3E4141413E;  7'h50: f = 40'h7F09090906;
            7'h51: f = 40'h3E4151215E;  7'h52: f = 40'h7F09192946;
            7'h53: f = 40'h4649494931;  7'h54: f = 40'h01017F0101;
            7'h55: f = 40'h3F4040403F;  7'h56: f = 40'h1F2040201F;
            7'h57: f = 40'h3F4038403F;  7'h58: f = 40'h6314081463;
            7'h59: f = 40'h0708700807;  7'h5A: f = 40'h6151494543;
            7'h5B: f = 40'h007F414100;  7'h5C: f = 40'h0204081020;
            7'h5D: f = 40'h0041417F00;  7'h5E: f = 40'h0402010204;
            7'h5F: f = 40'h4040404040;  7'h60: f = 40'h0001020400;
            7'h61: f = 40'h2054545478;  7'h62: f = 40'h7F48444438;
            7'h63: f = 40'h3844444420;  7'h64: f = 40'h384444487F;
            7'h65: f = 40'h3854545418;  7'h66: f = 40'h087E090102;
            7'h67: f = 40'h0C5252523E;  7'h68: f = 40'h7F08040478;
            7'h69: f = 40'h00447D4000;  7'h6A: f = 40'h2040443D00;
            7'h6B: f = 40'h7F10284400;  7'h6C: f = 40'h00417F4000;
            7'h6D: f = 40'h7C04180478;  7'h6E: f = 40'h7C08040478;
            7'h6F: f = 40'h3844444438;  7'h70: f = 40'h7C14141408;
            7'h71: f = 40'h081414187C;  7'h72: f = 40'h7C08040408;
            7'h73: f = 40'h4854545420;  7'h74: f = 40'h043F444020;
            7'h75: f = 40'h3C4040207C;  7'h76: f = 40'h1C2040201C;
            7'h77: f = 40'h3C4030403C;  7'h78: f = 40'h4428102844;
            7'h79: f = 40'h0C5050503C;  7'h7A: f = 40'h4464544C44;
            7'h7B: f = 40'h0008364100;  7'h7C: f = 40'h00007F0000;
            7'h7D: f = 40'h0041360800;  7'h7E: f = 40'h1008081008;
            default: f = 40'h0;         // space, control codes, DEL
        endcase
        return f;
    endfunction

    logic [39:0] raw;

    always_comb begin
        raw = font(code);
    end

    // Registered read, unpacked so glyph[0] is the leftmost column.
    always_ff @(posedge clk) begin
        for (int k = 0; k < int'(GLYPH_W); k++) begin
            glyph[k] <= raw[8*(int'(GLYPH_W)-1-k) +: 8];
        end
    end

endmodule

// File: rtl/lcd_text_writer.sv
// lcd_text_writer: character-cell front end for the 84x48 LCD bitmap port.
//   clk, rst        clock, asynchronous active-high reset
//   in_valid/ready  character handshake; in_char, in_row (0..5), in_col (0..13)
//   clr             clear-screen request (queued if the block is busy)
//   err             one-cycle pulse when an out-of-range position is dropped
//   req_o           one-cycle write strobe; bank_o, col_o, data_o hold between strobes
// Each character becomes 6 column writes (5 glyph + 1 blank), a clear becomes
// 504 zero writes; strobes are spaced WRITE_GAP cycles apart.
module lcd_text_writer
    import lcd_text_pkg::*;
#(
    parameter int unsigned WRITE_GAP = 4
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [6:0] in_char,
    input  logic [2:0] in_row,
    input  logic [3:0] in_col,
    input  logic       clr,
    output logic       err,
    output logic       req_o,
    output logic [2:0] bank_o,
    output logic [6:0] col_o,
    output logic [7:0] data_o
);

    state_t     state, state_n;
    logic [6:0] char_q, char_n;
    logic [2:0] row_q, row_n;
    logic [6:0] base_q, base_n;
    logic [2:0] k_q, k_n;
    logic [3:0] gap_q, gap_n;
    logic [2:0] cbank_q, cbank_n;
    logic [6:0] ccol_q, ccol_n;
    logic       clr_pend, clr_pend_n;
    logic       in_ready_n, err_n, req_n;
    logic [2:0] bank_n;
    logic [6:0] col_n;
    logic [7:0] data_n;
    glyph_t     glyph;

    lcd_font_rom u_font (
        .clk   (clk),
        .code  (char_q),
        .glyph (glyph)
    );

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            char_q   <= '0;
            row_q    <= '0;
            base_q   <= '0;
            k_q      <= '0;
            gap_q    <= '0;
            cbank_q  <= '0;
            ccol_q   <= '0;
            clr_pend <= 1'b0;
            in_ready <= 1'b0;
            err      <= 1'b0;
            req_o    <= 1'b0;
            bank_o   <= '0;
            col_o    <= '0;
            data_o   <= '0;
        end else begin
            state    <= state_n;
            char_q   <= char_n;
            row_q    <= row_n;
            base_q   <= base_n;
            k_q      <= k_n;
            gap_q    <= gap_n;
            cbank_q  <= cbank_n;
            ccol_q   <= ccol_n;
            clr_pend <= clr_pend_n;
            in_ready <= in_ready_n;
            err      <= err_n;
            req_o    <= req_n;
            bank_o   <= bank_n;
            col_o    <= col_n;
            data_o   <= data_n;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_n    = state;
        char_n     = char_q;
        row_n      = row_q;
        base_n     = base_q;
        k_n        = k_q;
        gap_n      = gap_q;
        cbank_n    = cbank_q;
        ccol_n     = ccol_q;
        clr_pend_n = clr_pend | (clr && (state != IDLE));
        err_n      = 1'b0;
        req_n      = 1'b0;
        bank_n     = bank_o;
        col_n      = col_o;
        data_n     = data_o;

        case (state)
            IDLE: begin
                if (clr_pend || clr) begin
                    state_n    = CLEAR_EMIT;
                    clr_pend_n = 1'b0;
                    cbank_n    = '0;
                    ccol_n     = '0;
                end else if (in_valid && in_ready) begin
                    if ((in_row >= 3'(TEXT_ROWS)) || (in_col >= 4'(TEXT_COLS))) begin
                        err_n = 1'b1;
                    end else begin
                        char_n  = in_char;
                        row_n   = in_row;
                        // in_col * 6 as shift-add
                        base_n  = 7'({in_col, 2'b00}) + 7'({in_col, 1'b0});
                        k_n     = '0;
                        state_n = LOAD;
                    end
                end
            end
            LOAD: begin
                state_n = EMIT;
            end
            EMIT: begin
                req_n   = 1'b1;
                bank_n  = row_q;
                col_n   = base_q + 7'(k_q);
                data_n  = (k_q < 3'(GLYPH_W)) ? glyph[k_q] : 8'h00;
                gap_n   = 4'(WRITE_GAP - 2);
                state_n = GAP;
            end
            GAP: begin
                if (gap_q != 4'd0) begin
                    gap_n = gap_q - 4'd1;
                end else if (k_q == 3'(CELL_W - 1)) begin
                    state_n = IDLE;
                end else begin
                    k_n     = k_q + 3'd1;
                    state_n = EMIT;
                end
            end
            CLEAR_EMIT: begin
                req_n   = 1'b1;
                bank_n  = cbank_q;
                col_n   = ccol_q;
                data_n  = 8'h00;
                gap_n   = 4'(WRITE_GAP - 2);
                state_n = CLEAR_GAP;
                if (ccol_q == 7'(LCD_COLS - 1)) begin
                    ccol_n  = '0;
                    cbank_n = cbank_q + 3'd1;
                end else begin
                    ccol_n  = ccol_q + 7'd1;
                end
            end
            CLEAR_GAP: begin
                // Bank counter stepping past the last bank marks the final write.
                if (gap_q != 4'd0) begin
                    gap_n = gap_q - 4'd1;
                end else if (cbank_q == 3'(LCD_BANKS)) begin
                    state_n = IDLE;
                end else begin
                    state_n = CLEAR_EMIT;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Ready only after a full cycle settled in IDLE with nothing to start.
        in_ready_n = (state == IDLE) && (state_n == IDLE);
    end

endmodule

// File: tb/tb_lcd_text_writer.sv
// tb_lcd_text_writer: scoreboard bench for lcd_text_writer.
//   Expected writes (cycle, bank, col, data) are queued when stimulus is driven
//   and checked by a monitor on each req_o pulse.
module tb_lcd_text_writer;
    import lcd_text_pkg::*;

    localparam int G = 4;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] in_char;
    logic [2:0] in_row;
    logic [3:0] in_col;
    logic       clr;
    logic       err;
    logic       req_o;
    logic [2:0] bank_o;
    logic [6:0] col_o;
    logic [7:0] data_o;

    typedef struct {
        int         cyc;
        logic [2:0] bank;
        logic [6:0] col;
        logic [7:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_w;
    int  cyc    = 0;
    int  n_req  = 0;
    int  n_tests = 0;
    int  n_fail  = 0;

    lcd_text_writer #(.WRITE_GAP(G)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_char  (in_char),
        .in_row   (in_row),
        .in_col   (in_col),
        .clr      (clr),
        .err      (err),
        .req_o    (req_o),
        .bank_o   (bank_o),
        .col_o    (col_o),
        .data_o   (data_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     tag, got, got, exp, exp, cyc);
        end
    endtask

    // Reference glyph columns for the characters used here (standard 5x7 font).
    function automatic logic [7:0] font_col(input logic [6:0] ch, input int k);
        logic [39:0] g;
        case (ch)
            7'h41:   g = 40'h7E1111117E;  // 'A'
            7'h42:   g = 40'h7F49494936;  // 'B'
            7'h30:   g = 40'h3E5149453E;  // '0'
            default: g = 40'h0;
        endcase
        if (k > 4) return 8'h00;
        return g[8*(4-k) +: 8];
    endfunction

    task automatic push_glyph(input int t, input logic [6:0] ch,
                              input logic [2:0] row, input logic [3:0] col);
        wr_t w;
        for (int k = 0; k < 6; k++) begin
            w.cyc  = t + 2 + k*G;
            w.bank = row;
            w.col  = 7'(int'(col)*6 + k);
            w.data = font_col(ch, k);
            exp_q.push_back(w);
        end
    endtask

    task automatic push_clear(input int c);
        wr_t w;
        for (int i = 0; i < int'(CLEAR_WRITES); i++) begin
            w.cyc  = c + 1 + i*G;
            w.bank = 3'(i / 84);
            w.col  = 7'(i % 84);
            w.data = 8'h00;
            exp_q.push_back(w);
        end
    endtask

    // Caller is at a negedge; waits (bounded) until the block is ready, returns acceptance edge.
    task automatic send_char(input logic [6:0] ch, input logic [2:0] row,
                             input logic [3:0] col, input int budget, output int t);
        int waited;
        waited   = 0;
        in_char  = ch;
        in_row   = row;
        in_col   = col;
        in_valid = 1'b1;
        while (!in_ready && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check_eq("accept_timeout", int'(in_ready), 1);
        t = cyc + 1;
        push_glyph(t, ch, row, col);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic char_op(input logic [6:0] ch, input logic [2:0] row, input logic [3:0] col);
        int t;
        send_char(ch, row, col, 50, t);
        wait_cyc(t + 1 + 6*G);
        check_eq("ready_low_before_done", int'(in_ready), 0);
        wait_cyc(t + 2 + 6*G);
        check_eq("ready_high_after_char", int'(in_ready), 1);
        check_eq("queue_drained_char", exp_q.size(), 0);
    endtask

    // Scoreboard monitor: compares every write strobe, flags missed and extra ones.
    always @(negedge clk) begin
        if (!rst) begin
            if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
                check_eq("missing_req", cyc, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (req_o) begin
                n_req++;
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_req", int'(req_o), 0);
                end else begin
                    mon_w = exp_q.pop_front();
                    check_eq("req_cycle", cyc, mon_w.cyc);
                    check_eq("bank", int'(bank_o), int'(mon_w.bank));
                    check_eq("col", int'(col_o), int'(mon_w.col));
                    check_eq("data", int'(data_o), int'(mon_w.data));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t, tb, c, n0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_char  = '0;
        in_row   = '0;
        in_col   = '0;
        clr      = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_in_ready", int'(in_ready), 0);
        check_eq("rst_err", int'(err), 0);
        check_eq("rst_req", int'(req_o), 0);
        check_eq("rst_bank", int'(bank_o), 0);
        check_eq("rst_col", int'(col_o), 0);
        check_eq("rst_data", int'(data_o), 0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("ready_after_rst", int'(in_ready), 1);

        // Glyphs at both grid corners, a mid-grid digit, and a control code.
        char_op(7'h41, 3'd0, 4'd0);
        char_op(7'h41, 3'd5, 4'd13);
        char_op(7'h30, 3'd2, 4'd7);
        char_op(7'h07, 3'd1, 4'd4);

        // Out-of-range positions are dropped with an error pulse.
        for (int i = 0; i < 2; i++) begin
            in_char  = 7'h41;
            in_row   = (i == 0) ? 3'd0 : 3'd6;
            in_col   = (i == 0) ? 4'd14 : 4'd0;
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            check_eq("err_pulse", int'(err), 1);
            check_eq("err_ready_kept", int'(in_ready), 1);
            @(negedge clk);
            check_eq("err_one_cycle", int'(err), 0);
            check_eq("err_ready_after", int'(in_ready), 1);
        end
        repeat (4) @(negedge clk);

        // Clear from IDLE.
        clr = 1'b1;
        c = cyc + 1;
        push_clear(c);
        @(negedge clk);
        clr = 1'b0;
        check_eq("clear_ready_drop", int'(in_ready), 0);
        wait_cyc(c + int'(CLEAR_WRITES)*G);
        check_eq("clear_ready_low_end", int'(in_ready), 0);
        wait_cyc(c + int'(CLEAR_WRITES)*G + 1);
        check_eq("clear_ready_high", int'(in_ready), 1);
        check_eq("queue_drained_clear", exp_q.size(), 0);

        // Clear requested mid-glyph: glyph finishes, clear follows, next char waits.
        send_char(7'h41, 3'd1, 4'd3, 50, t);
        wait_cyc(t + 3);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        c = t + 2 + 6*G;
        push_clear(c);
        send_char(7'h42, 3'd4, 4'd9, 3000, tb);
        check_eq("held_off_accept", tb, c + int'(CLEAR_WRITES)*G + 2);
        wait_cyc(tb + 2 + 6*G);
        check_eq("ready_after_queued", int'(in_ready), 1);
        check_eq("queue_drained_queued", exp_q.size(), 0);

        // Reset between the second and third glyph writes.
        send_char(7'h41, 3'd3, 4'd2, 50, t);
        wait_cyc(t + 2 + G + 1);
        #3;
        rst = 1'b1;
        #1;
        exp_q.delete();
        check_eq("abort_req", int'(req_o), 0);
        check_eq("abort_bank", int'(bank_o), 0);
        check_eq("abort_col", int'(col_o), 0);
        check_eq("abort_data", int'(data_o), 0);
        check_eq("abort_ready", int'(in_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("ready_after_abort", int'(in_ready), 1);
        n0 = n_req;
        repeat (40) @(negedge clk);
        check_eq("no_req_after_abort", n_req, n0);
        check_eq("final_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
